// File: rtl/qam_pkg.sv
// rtl/qam_pkg.sv - shared types and default widths for the QAM carrier sequencer
package qam_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int SPS_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_SIN = 3'd1,
    ST_RD_COS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } qam_state_e;

  typedef logic [1:0] quad_t;

endpackage

// File: rtl/qam_quadrant_map.sv
// rtl/qam_quadrant_map.sv - maps top phase bits plus quadrant offset to quarter-wave ROM address and sign
module qam_quadrant_map
  import qam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W+1:0] ph_i,
  input  quad_t             qadd_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              neg_o
);

  quad_t             q;
  logic [ADDR_W-1:0] idx;

  assign q      = quad_t'(ph_i[ADDR_W+1 -: 2] + qadd_i);
  assign idx    = ph_i[ADDR_W-1:0];
  // odd quadrants run the quarter-wave backwards, upper half is negative
  assign addr_o = q[0] ? ~idx : idx;
  assign neg_o  = q[1];

endmodule

// File: rtl/qam_carrier_seq.sv
// rtl/qam_carrier_seq.sv - phase accumulator and sin/cos ROM sequencer for the QAM mixer
// Optional lookup phase offset input enabled by QAM_PHASE_OFFSET_EN.
module qam_carrier_seq
  import qam_pkg::*;
#(
  parameter int PHASE_W         = PHASE_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int SAMPLES_PER_SYM = SPS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_load,
`ifdef QAM_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0] phase_offset,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_rd,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sym_strobe
);

  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

  qam_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, fcw_q, lp;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q, map_addr;
  logic [DATA_W-1:0] sin_q, cos_q, data_s;
  logic              neg_q, map_neg, sym_q, hs;
  quad_t             qadd;
  logic              unused_lp_bits;

`ifdef QAM_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] off_q;
  // offset is live in RD_SIN and held for the cosine read of the same sample
  assign lp = phase_q + ((state_q == ST_RD_SIN) ? phase_offset : off_q);
`else
  assign lp = phase_q;
`endif

  assign unused_lp_bits = ^lp[PHASE_W-ADDR_W-3:0];
  assign qadd   = (state_q == ST_RD_COS) ? quad_t'(1) : quad_t'(0);
  assign hs     = (state_q == ST_HOLD) && out_ready;
  assign data_s = neg_q ? (~rom_data) + DATA_W'(1) : rom_data;

  qam_quadrant_map #(.ADDR_W(ADDR_W)) u_map (
    .ph_i   (lp[PHASE_W-1 -: ADDR_W+2]),
    .qadd_i (qadd),
    .addr_o (map_addr),
    .neg_o  (map_neg)
  );

  assign rom_rd     = (state_q == ST_RD_SIN) || (state_q == ST_RD_COS);
  assign rom_addr   = rom_rd ? map_addr : addr_q;
  assign out_valid  = (state_q == ST_HOLD);
  assign sin_out    = sin_q;
  assign cos_out    = cos_q;
  assign sym_strobe = sym_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en) state_d = ST_RD_SIN;
      ST_RD_SIN: state_d = ST_RD_COS;
      ST_RD_COS: state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_HOLD;
      ST_HOLD:   if (out_ready) state_d = en ? ST_RD_SIN : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      fcw_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      neg_q   <= 1'b0;
      sym_q   <= 1'b0;
`ifdef QAM_PHASE_OFFSET_EN
      off_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= rom_addr;
      sym_q   <= hs && (cnt_q == CNT_LAST);
      if (fcw_load) fcw_q <= fcw;
      if (hs) begin
        phase_q <= phase_q + fcw_q;
        cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      // sign travels one cycle behind its address to meet the returning data
      if (rom_rd) neg_q <= map_neg;
      if (state_q == ST_RD_COS) sin_q <= data_s;
      if (state_q == ST_WAIT) cos_q <= data_s;
`ifdef QAM_PHASE_OFFSET_EN
      if (state_q == ST_RD_SIN) off_q <= phase_offset;
`endif
    end
  end

endmodule

// File: tb/tb_qam_carrier_seq.sv
// tb/tb_qam_carrier_seq.sv - directed self-checking bench for qam_carrier_seq
module tb_qam_carrier_seq;

  localparam int PW = 16;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, en, fcw_load, rom_rd, out_valid, out_ready, sym_strobe;
  logic [PW-1:0] fcw;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, sin_out, cos_out;
`ifdef QAM_PHASE_OFFSET_EN
  logic [PW-1:0] phase_offset;
`endif

  int checks = 0;
  int errors = 0;
  int hs, strobes;
  logic prev_sym;
  logic [DW-1:0] last_sin, last_cos;

  always #5 clk = ~clk;

  qam_carrier_seq dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fcw        (fcw),
    .fcw_load   (fcw_load),
`ifdef QAM_PHASE_OFFSET_EN
    .phase_offset (phase_offset),
`endif
    .rom_addr   (rom_addr),
    .rom_rd     (rom_rd),
    .rom_data   (rom_data),
    .sin_out    (sin_out),
    .cos_out    (cos_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sym_strobe (sym_strobe)
  );

  function automatic logic [DW-1:0] f(input int i);
    return DW'(i * 97 + 3);
  endfunction

  function automatic logic [DW-1:0] ng(input logic [DW-1:0] x);
    return ~x + 16'd1;
  endfunction

  always @(posedge clk) if (rom_rd) rom_data <= f(int'(rom_addr));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fcw = '0; fcw_load = 1'b0; out_ready = 1'b1;
`ifdef QAM_PHASE_OFFSET_EN
    phase_offset = '0;
`endif
    tick; tick;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_rd", {31'd0, rom_rd}, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_sym", {31'd0, sym_strobe}, 0);
    chk("rst_addr", rom_addr, 0);

    // first sample at phase 0
    rst = 1'b0; fcw = 16'h0100; fcw_load = 1'b1;
    tick;
    fcw_load = 1'b0; en = 1'b1;
    tick;
    chk("s1_rd_sin", {31'd0, rom_rd}, 1);
    chk("s1_sin_addr", rom_addr, 0);
    tick;
    chk("s1_cos_addr", rom_addr, 255);
    tick;
    chk("s1_wait_rd", {31'd0, rom_rd}, 0);
    chk("s1_wait_valid", {31'd0, out_valid}, 0);
    chk("s1_addr_hold", rom_addr, 255);
    tick;
    chk("s1_valid", {31'd0, out_valid}, 1);
    chk("s1_sin", sin_out, f(0));
    chk("s1_cos", cos_out, f(255));

    // load during handshake: this advance still uses 0x0100
    fcw = 16'h3F00; fcw_load = 1'b1;
    tick;
    fcw_load = 1'b0;
    chk("s2_valid_drop", {31'd0, out_valid}, 0);
    chk("s2_sin_addr", rom_addr, 4);
    wait_valid("s2_timeout");
    chk("s2_sin", sin_out, f(4));
    chk("s2_cos", cos_out, f(251));

    tick;
    wait_valid("p4000_timeout");
    chk("p4000_sin", sin_out, f(255));
    chk("p4000_cos", cos_out, ng(f(0)));

    fcw = 16'h4000; fcw_load = 1'b1;
    tick;
    fcw_load = 1'b0;
    wait_valid("p7f00_timeout");
    chk("p7f00_sin", sin_out, f(3));
    chk("p7f00_cos", cos_out, ng(f(252)));

    tick;
    wait_valid("pbf00_timeout");
    chk("pbf00_sin", sin_out, ng(f(252)));
    chk("pbf00_cos", cos_out, ng(f(3)));

    fcw = 16'h8100; fcw_load = 1'b1;
    tick;
    fcw_load = 1'b0;
    wait_valid("pff00_timeout");
    chk("pff00_sin", sin_out, ng(f(3)));
    chk("pff00_cos", cos_out, f(252));

    tick;
    wait_valid("p8000_timeout");
    chk("p8000_sin", sin_out, ng(f(0)));
    chk("p8000_cos", cos_out, ng(f(255)));

    // back-pressure for 5 cycles in HOLD
    out_ready = 1'b0; fcw = 16'h0100; fcw_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      fcw_load = 1'b0;
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_rd", {31'd0, rom_rd}, 0);
      chk("stall_sin", sin_out, ng(f(0)));
      chk("stall_cos", cos_out, ng(f(255)));
    end
    out_ready = 1'b1;
    tick;
    chk("stall_release_addr", rom_addr, 4);
    chk("stall_release_rd", {31'd0, rom_rd}, 1);

    // reset while in RD_COS
    tick;
    chk("p8100_cos_addr", rom_addr, 251);
    rst = 1'b1;
    tick;
    chk("rst_cos_valid", {31'd0, out_valid}, 0);
    chk("rst_cos_rd", {31'd0, rom_rd}, 0);
    chk("rst_cos_sym", {31'd0, sym_strobe}, 0);
    chk("rst_cos_sin", sin_out, 0);
    chk("rst_cos_addr", rom_addr, 0);
    rst = 1'b0; fcw = 16'h0100; fcw_load = 1'b1;
    tick;
    fcw_load = 1'b0;
    chk("restart_rd", {31'd0, rom_rd}, 1);
    chk("restart_addr", rom_addr, 0);

    // 40 accepted samples, strobe after handshakes 16 and 32
    hs = 0; strobes = 0; prev_sym = 1'b0; last_sin = '0; last_cos = '0;
    for (int i = 0; i < 250 && hs < 40; i++) begin
      tick;
      if (sym_strobe) begin
        strobes++;
        chk((strobes == 1) ? "sym_first" : "sym_second", hs, (strobes == 1) ? 16 : 32);
        chk("sym_width", {31'd0, prev_sym}, 0);
      end
      prev_sym = sym_strobe;
      if (out_valid) begin
        if (hs == 39) begin
          last_sin = sin_out;
          last_cos = cos_out;
        end
        hs++;
      end
    end
    chk("hs_count", hs, 40);
    chk("sym_count", strobes, 2);
    chk("s40_sin", last_sin, f(156));
    chk("s40_cos", last_cos, f(99));

    // en dropped mid-sample: sample completes, then idle
    tick;
    chk("post40_sym", {31'd0, sym_strobe}, 0);
    en = 1'b0;
    tick;
    chk("en_off_rd_cos", {31'd0, rom_rd}, 1);
    wait_valid("en_off_timeout");
    chk("en_off_sin", sin_out, f(160));
    chk("en_off_cos", cos_out, f(95));
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_rd", {31'd0, rom_rd}, 0);
      chk("idle_valid", {31'd0, out_valid}, 0);
      chk("idle_sin", sin_out, f(160));
    end

`ifdef QAM_PHASE_OFFSET_EN
    rst = 1'b1;
    tick;
    rst = 1'b0; phase_offset = 16'h4000; en = 1'b1;
    tick;
    wait_valid("off_timeout");
    chk("off_sin", sin_out, f(255));
    chk("off_cos", cos_out, ng(f(0)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
